// File: rtl/restoring_divider_8bit.sv
// Sequential unsigned 8-bit restoring divider that produces one quotient bit per clock.
// A single subtractor_8bit provides both the trial difference and the compare (its carry-out).
module subtractor_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] diff,
  output logic       c
);
  logic [8:0] sum;

  // a + ~b + 1: carry-out is set exactly when no borrow occurs, i.e. a >= b
  assign sum  = {1'b0, a} + {1'b0, ~b} + 9'd1;
  assign diff = sum[7:0];
  assign c    = sum[8];
endmodule

module restoring_divider_8bit #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] DZ_QUOTIENT = 8'hFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] divr_q, divr_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dz_q, dz_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] trial;
  logic [WIDTH-1:0] diff;
  logic             sub_c;
  logic             take;
  logic [WIDTH-1:0] r_nxt;
  logic [WIDTH-1:0] q_nxt;

  assign trial = {r_q[6:0], q_q[7]};

  subtractor_8bit u_sub (
    .a    (trial),
    .b    (divr_q),
    .diff (diff),
    .c    (sub_c)
  );

  // R[7] set means the shifted partial remainder is a 9-bit value >= 256, always >= divisor
  assign take  = r_q[7] | sub_c;
  assign r_nxt = take ? diff : trial;
  assign q_nxt = {q_q[6:0], take};

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    q_d         = q_q;
    divr_d      = divr_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dz_d        = dz_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          r_d    = '0;
          q_d    = dividend;
          divr_d = divisor;
          cnt_d  = '0;
          dz_d   = 1'b0;
          if (divisor == '0) begin
            state_d     = DONE;
            quotient_d  = DZ_QUOTIENT;
            remainder_d = dividend;
            dz_d        = 1'b1;
          end else begin
            state_d = CALC;
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      CALC: begin
        r_d   = r_nxt;
        q_d   = q_nxt;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d     = DONE;
          quotient_d  = q_nxt;
          remainder_d = r_nxt;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d != CALC);
    busy_d  = (state_d == CALC);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      r_q         <= '0;
      q_q         <= '0;
      divr_q      <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dz_q        <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      q_q         <= q_d;
      divr_q      <= divr_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dz_q        <= dz_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign ready       = ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dz_q;
endmodule

// File: tb/tb_restoring_divider_8bit.sv
// Directed and table-driven bench for restoring_divider_8bit, with corner sequences and a random sweep.
module tb_restoring_divider_8bit;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       ready;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] exp_q;
    logic [7:0] exp_r;
    logic       exp_dz;
    int         exp_lat;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  restoring_divider_8bit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .ready       (ready),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Pulse start for one edge, then count edges (including the accept edge) until done
  task automatic run_op(input logic [7:0] a, input logic [7:0] d, output int edges);
    dividend = a;
    divisor  = d;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    edges = 1;
    while (!done && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  initial begin
    int lat;
    int busy_cnt;
    int saw_done;
    logic [7:0] ra, rd, eq, er;

    vecs[0] = '{8'd200, 8'd7,   8'd28,  8'd4,    1'b0, 9};
    vecs[1] = '{8'hFF,  8'h01,  8'hFF,  8'h00,   1'b0, 9};
    vecs[2] = '{8'h80,  8'hFF,  8'h00,  8'h80,   1'b0, 9};
    vecs[3] = '{8'h2A,  8'h00,  8'hFF,  8'h2A,   1'b1, 1};
    vecs[4] = '{8'h00,  8'h05,  8'h00,  8'h00,   1'b0, 9};
    vecs[5] = '{8'hFF,  8'hFF,  8'h01,  8'h00,   1'b0, 9};
    vecs[6] = '{8'd7,   8'd9,   8'd0,   8'd7,    1'b0, 9};
    vecs[7] = '{8'hFE,  8'h80,  8'h01,  8'h7E,   1'b0, 9};
    vecs[8] = '{8'd200, 8'd201, 8'd0,   8'd200,  1'b0, 9};
    vecs[9] = '{8'd255, 8'd16,  8'd15,  8'd15,   1'b0, 9};

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_quotient", quotient, 0);
    chk("reset_remainder", remainder, 0);
    chk("reset_dz", div_by_zero, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].d, lat);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("vec%0d_quotient", i), quotient, vecs[i].exp_q);
      chk($sformatf("vec%0d_remainder", i), remainder, vecs[i].exp_r);
      chk($sformatf("vec%0d_dz", i), div_by_zero, vecs[i].exp_dz);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_done_pulse", i), done, 0);
      chk($sformatf("vec%0d_idle_ready", i), ready, 1);
      chk($sformatf("vec%0d_held_q", i), quotient, vecs[i].exp_q);
    end

    // Starts and operand changes during CALC must be ignored
    dividend = 8'd50;
    divisor  = 8'd6;
    start    = 1'b1;
    @(posedge clk);
    #1;
    busy_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy && !ready) busy_cnt++;
      if (i < 7) begin
        dividend = 8'(i * 3 + 1);
        divisor  = 8'(i + 2);
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    chk("ignore_busy_cycles", busy_cnt, 8);
    chk("ignore_done", done, 1);
    chk("ignore_quotient", quotient, 8);
    chk("ignore_remainder", remainder, 2);
    chk("ignore_busy_after", busy, 0);

    // Back-to-back: start held in DONE is re-accepted without an IDLE gap
    run_op(8'd20, 8'd4, lat);
    chk("b2b_first_q", quotient, 5);
    dividend = 8'd9;
    divisor  = 8'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_busy", busy, 1);
    chk("b2b_done_low", done, 0);
    chk("b2b_held_q", quotient, 5);
    repeat (8) @(posedge clk);
    #1;
    chk("b2b_done", done, 1);
    chk("b2b_quotient", quotient, 3);
    chk("b2b_remainder", remainder, 0);

    // Back-to-back divide-by-zero keeps done high for consecutive cycles
    @(posedge clk);
    #1;
    run_op(8'h11, 8'h00, lat);
    chk("dz1_latency", lat, 1);
    dividend = 8'h33;
    divisor  = 8'h00;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("dz2_done", done, 1);
    chk("dz2_remainder", remainder, 8'h33);
    chk("dz2_dz", div_by_zero, 1);
    @(posedge clk);
    #1;

    // Reset in the middle of iteration aborts the operation
    dividend = 8'd77;
    divisor  = 8'd5;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_ready", ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_quotient", quotient, 0);
    chk("abort_remainder", remainder, 0);
    chk("abort_dz", div_by_zero, 0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    saw_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1;
    end
    chk("abort_no_done", saw_done, 0);
    run_op(8'd100, 8'd10, lat);
    chk("post_abort_latency", lat, 9);
    chk("post_abort_quotient", quotient, 10);
    chk("post_abort_remainder", remainder, 0);

    // Random sweep against the / and % reference
    for (int i = 0; i < 200; i++) begin
      ra = 8'($urandom_range(0, 255));
      rd = 8'($urandom_range(0, 255));
      if (i % 40 == 0) rd = 8'd0;
      if (rd == 0) begin
        eq = 8'hFF;
        er = ra;
      end else begin
        eq = ra / rd;
        er = ra % rd;
      end
      run_op(ra, rd, lat);
      chk($sformatf("rand_%0d_%0d_latency", ra, rd), lat, (rd == 0) ? 1 : 9);
      chk($sformatf("rand_%0d_%0d_quotient", ra, rd), quotient, eq);
      chk($sformatf("rand_%0d_%0d_remainder", ra, rd), remainder, er);
      chk($sformatf("rand_%0d_%0d_dz", ra, rd), div_by_zero, (rd == 0) ? 1 : 0);
      @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
